// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one external combinational ALU between two requesters. A request
//   is accepted in IDLE, executed for one cycle in EXEC (the ALU is driven
//   only then), and its result is held on a shared response bus in RESP
//   until the owning requester takes it. Illegal control codes skip EXEC and
//   return an error response.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   reqN_valid / reqN_ready       request handshake per requester (N = 0, 1)
//   reqN_a, reqN_b, reqN_gin      operands and ALU control code
//   rspN_valid / rspN_ready       response handshake per requester
//   rsp_sum, rsp_zout, rsp_err    shared result bus (err = illegal code)
//   alu_a, alu_b, alu_gin         drive to the shared ALU (0 outside EXEC)
//   alu_sum, alu_zout             combinational ALU result
module alu_arbiter #(
  parameter int DW        = 32,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [3:0]    req0_gin,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [3:0]    req1_gin,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp_sum,
  output logic          rsp_zout,
  output logic          rsp_err,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_gin,
  input  logic [DW-1:0] alu_sum,
  input  logic          alu_zout
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] a_p0, b_p0;
  logic [3:0]    gin_p0;
  logic          owner_p0;
  logic          last_q;      // requester served most recently
  logic          grant0, grant1;
  logic          accept;
  logic [3:0]    acc_gin;

  function automatic logic gin_legal(input logic [3:0] g);
    case (g)
      4'b0010, 4'b0110, 4'b0111, 4'b0000,
      4'b0001, 4'b1010, 4'b1001, 4'b1000: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Round-robin favours the requester not served last; fixed priority
  // always favours requester 0 on a tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (FIXED_PRI || last_q) grant0 = 1'b1;
      else                     grant1 = 1'b1;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Ready is gated by rst_n so request inputs are ignored during reset.
  assign req0_ready = rst_n && (state_q == IDLE) && grant0;
  assign req1_ready = rst_n && (state_q == IDLE) && grant1;
  assign accept     = req0_ready || req1_ready;
  assign acc_gin    = req1_ready ? req1_gin : req0_gin;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = gin_legal(acc_gin) ? EXEC : RESP;
      EXEC: state_d = RESP;
      RESP: if (owner_p0 ? rsp1_ready : rsp0_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Accept stage: capture the winning request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_p0     <= '0;
      b_p0     <= '0;
      gin_p0   <= '0;
      owner_p0 <= 1'b0;
      last_q   <= 1'b1;
    end else if (accept) begin
      a_p0     <= req1_ready ? req1_a : req0_a;
      b_p0     <= req1_ready ? req1_b : req0_b;
      gin_p0   <= acc_gin;
      owner_p0 <= req1_ready;
      last_q   <= req1_ready;
    end
  end

  // Response stage: capture the ALU result at the end of EXEC, or an error
  // response directly at accept for an illegal code
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_sum  <= '0;
      rsp_zout <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (state_q == IDLE && accept && !gin_legal(acc_gin)) begin
      rsp_sum  <= '0;
      rsp_zout <= 1'b0;
      rsp_err  <= 1'b1;
    end else if (state_q == EXEC) begin
      rsp_sum  <= alu_sum;
      rsp_zout <= alu_zout;
      rsp_err  <= 1'b0;
    end
  end

  assign rsp0_valid = (state_q == RESP) && !owner_p0;
  assign rsp1_valid = (state_q == RESP) &&  owner_p0;

  assign alu_a   = (state_q == EXEC) ? a_p0   : '0;
  assign alu_b   = (state_q == EXEC) ? b_p0   : '0;
  assign alu_gin = (state_q == EXEC) ? gin_p0 : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]    req0_gin, req1_gin;

  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zout, rsp_err, alu_zout;
  logic [DW-1:0] rsp_sum, alu_a, alu_b, alu_sum;
  logic [3:0]    alu_gin;

  logic          f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_rsp_zout, f_rsp_err, f_alu_zout;
  logic [DW-1:0] f_rsp_sum, f_alu_a, f_alu_b, f_alu_sum;
  logic [3:0]    f_alu_gin;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference ALU attached to each DUT
  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [3:0] g);
    case (g)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b1010: return ~(a | b);
      4'b1001: return a ^ b;
      4'b1000: return a;
      default: return '0;
    endcase
  endfunction

  assign alu_sum    = alu_f(alu_a, alu_b, alu_gin);
  assign alu_zout   = (alu_sum == '0);
  assign f_alu_sum  = alu_f(f_alu_a, f_alu_b, f_alu_gin);
  assign f_alu_zout = (f_alu_sum == '0);

  alu_arbiter #(.DW(DW), .FIXED_PRI(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_gin(req0_gin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_gin(req1_gin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_sum(rsp_sum), .rsp_zout(rsp_zout), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_gin(alu_gin), .alu_sum(alu_sum), .alu_zout(alu_zout)
  );

  alu_arbiter #(.DW(DW), .FIXED_PRI(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_gin(req0_gin),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_gin(req1_gin),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_sum(f_rsp_sum), .rsp_zout(f_rsp_zout), .rsp_err(f_rsp_err),
    .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_gin(f_alu_gin), .alu_sum(f_alu_sum), .alu_zout(f_alu_zout)
  );

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  g;
    logic [31:0] es;
    logic        ez;
    logic        ee;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input vec_t v);
    int n;
    int lat;
    @(negedge clk);
    if (v.id == 0) begin
      req0_a = v.a; req0_b = v.b; req0_gin = v.g; req0_valid = 1'b1; rsp0_ready = 1'b1;
    end else begin
      req1_a = v.a; req1_b = v.b; req1_gin = v.g; req1_valid = 1'b1; rsp1_ready = 1'b1;
    end
    #1;
    n = 0;
    while (!(v.id == 0 ? req0_ready : req1_ready) && n < 8) begin
      @(negedge clk); #1; n++;
    end
    chk("grant_seen", 32'(n < 8), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    lat = 1;
    while (!(v.id == 0 ? rsp0_valid : rsp1_valid) && lat < 6) begin
      chk("alu_gin_exec", 32'(alu_gin), 32'(v.g));
      chk("alu_a_exec", alu_a, v.a);
      @(negedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), 32'(v.lat));
    if (v.ee) chk("alu_gin_err", 32'(alu_gin), 32'd0);
    chk("other_rsp_valid", 32'(v.id == 0 ? rsp1_valid : rsp0_valid), 32'd0);
    chk("rsp_sum", rsp_sum, v.es);
    chk("rsp_zout", 32'(rsp_zout), 32'(v.ez));
    chk("rsp_err", 32'(rsp_err), 32'(v.ee));
    @(negedge clk); #1;
    chk("rsp_done", 32'(rsp0_valid | rsp1_valid), 32'd0);
  endtask

  initial begin
    int gq[$];
    int fp_bad;
    int fp_g0;

    vecs[0]  = '{0, 32'd5,        32'd3,        4'b0010, 32'd8,        1'b0, 1'b0, 2};
    vecs[1]  = '{1, 32'd7,        32'd7,        4'b0110, 32'd0,        1'b1, 1'b0, 2};
    vecs[2]  = '{0, 32'd2,        32'd5,        4'b0111, 32'd1,        1'b0, 1'b0, 2};
    vecs[3]  = '{1, 32'hFFFFFFFF, 32'd1,        4'b0111, 32'd1,        1'b0, 1'b0, 2};
    vecs[4]  = '{0, 32'h0000F0F0, 32'h0000FF00, 4'b0000, 32'h0000F000, 1'b0, 1'b0, 2};
    vecs[5]  = '{1, 32'h0000F0F0, 32'h00000F0F, 4'b0001, 32'h0000FFFF, 1'b0, 1'b0, 2};
    vecs[6]  = '{0, 32'd0,        32'd0,        4'b1010, 32'hFFFFFFFF, 1'b0, 1'b0, 2};
    vecs[7]  = '{1, 32'hAAAA5555, 32'hFFFF0000, 4'b1001, 32'h55555555, 1'b0, 1'b0, 2};
    vecs[8]  = '{0, 32'h00001234, 32'd99,       4'b1000, 32'h00001234, 1'b0, 1'b0, 2};
    vecs[9]  = '{1, 32'd4,        32'd9,        4'b0011, 32'd0,        1'b0, 1'b1, 1};
    vecs[10] = '{0, 32'd4,        32'd9,        4'b1111, 32'd0,        1'b0, 1'b1, 1};
    vecs[11] = '{0, 32'd1,        32'd1,        4'b0110, 32'd0,        1'b1, 1'b0, 2};

    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'd5; req0_b = 32'd3; req0_gin = 4'b0010;
    req1_a = 32'd7; req1_b = 32'd7; req1_gin = 4'b0110;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    // Reset state, with requests asserted
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp0_valid | rsp1_valid), 32'd0);
    chk("rst_rsp_sum", rsp_sum, 32'd0);
    chk("rst_rsp_flags", 32'({rsp_zout, rsp_err}), 32'd0);
    chk("rst_alu", alu_a | alu_b | 32'(alu_gin), 32'd0);
    chk("rst_fp_ready", 32'(f_req0_ready | f_req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_op(vecs[i]);

    // Both requesters valid continuously: round-robin vs fixed priority
    do_reset();
    req0_a = 32'd5; req0_b = 32'd3; req0_gin = 4'b0010;
    req1_a = 32'd7; req1_b = 32'd7; req1_gin = 4'b0110;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    fp_bad = 0; fp_g0 = 0;
    for (int c = 0; c < 20; c++) begin
      if (req0_ready) gq.push_back(0);
      if (req1_ready) gq.push_back(1);
      if (f_req1_ready) fp_bad++;
      if (f_req0_ready) fp_g0++;
      if (rsp1_valid) begin
        chk("rr_sub_sum", rsp_sum, 32'd0);
        chk("rr_sub_zout", 32'(rsp_zout), 32'd1);
      end
      if (f_rsp0_valid) chk("fp_add_sum", f_rsp_sum, 32'd8);
      @(negedge clk); #1;
    end
    chk("rr_grant_count", 32'(gq.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("rr_grant_order", 32'(gq[i]), 32'(i % 2));
    chk("fp_req1_ready", 32'(fp_bad), 32'd0);
    chk("fp_req0_grants", 32'(fp_g0 >= 4), 32'd1);

    // Owner stalls its response for 4 cycles
    do_reset();
    req0_a = 32'd9; req0_b = 32'd4; req0_gin = 4'b0010; rsp0_ready = 1'b0;
    req1_a = 32'd1; req1_b = 32'd1; req1_gin = 4'b0010; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("stall_grant0", 32'(req0_ready), 32'd1);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk("stall_exec_req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk); #1;
    chk("stall_rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("stall_rsp_sum", rsp_sum, 32'd13);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("stall_hold_valid", 32'(rsp0_valid), 32'd1);
      chk("stall_hold_sum", rsp_sum, 32'd13);
      chk("stall_req1_ready", 32'(req1_ready), 32'd0);
      chk("stall_rsp1_valid", 32'(rsp1_valid), 32'd0);
    end
    rsp0_ready = 1'b1; #1;
    chk("stall_hs_req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk); #1;
    chk("stall_after_valid", 32'(rsp0_valid), 32'd0);
    chk("stall_after_req1_ready", 32'(req1_ready), 32'd1);
    req1_valid = 1'b0; #1;
    // Withdrawn request leaves no trace
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("withdraw_rsp1", 32'(rsp1_valid), 32'd0);
      chk("withdraw_alu", 32'(alu_gin), 32'd0);
    end

    // Reset during EXEC aborts the operation
    do_reset();
    req0_a = 32'd2; req0_b = 32'd2; req0_gin = 4'b0010; rsp0_ready = 1'b1;
    req0_valid = 1'b1; #1;
    chk("abort_grant", 32'(req0_ready), 32'd1);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk("abort_exec_gin", 32'(alu_gin), 32'b0010);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("abort_rsp_valid", 32'(rsp0_valid | rsp1_valid), 32'd0);
    chk("abort_alu", alu_a | alu_b | 32'(alu_gin), 32'd0);
    chk("abort_rsp_sum", rsp_sum, 32'd0);
    chk("abort_ready", 32'(req0_ready | req1_ready), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("abort_no_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
